// File: rtl/cohort_resp_pkg.sv
// Shared types for the Cohort memory responder: request encoding, the queued
// request entry and the read-modify-write helper used by the executor.
package cohort_resp_pkg;

    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam int TAG_W  = 8;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        STORE    = 3'd1,
        AMO_ADD  = 3'd2,
        AMO_SWAP = 3'd3,
        CAS      = 3'd4
    } req_type_e;

    typedef struct packed {
        req_type_e          req_type;
        logic [TAG_W-1:0]   mshrid;
        logic [ADDR_W-1:0]  address;
        logic [MASK_W-1:0]  write_mask;
        logic [DATA_W-1:0]  data_0;
        logic [DATA_W-1:0]  data_1;
    } req_entry_t;

    typedef struct packed {
        logic [DATA_W-1:0]  new_word;
        logic               write_en;
    } amo_result_t;

    // Unknown encodings fall through to the default arm and behave as LOAD.
    function automatic amo_result_t amo_compute(input logic [DATA_W-1:0] old,
                                                 input req_entry_t entry);
        amo_result_t res;
        res.new_word = old;
        res.write_en = 1'b0;
        case (entry.req_type)
            STORE: begin
                for (int b = 0; b < MASK_W; b++) begin
                    if (entry.write_mask[b]) begin
                        res.new_word[8*b +: 8] = entry.data_0[8*b +: 8];
                    end
                end
                res.write_en = 1'b1;
            end
            AMO_ADD: begin
                res.new_word = old + entry.data_0;
                res.write_en = 1'b1;
            end
            AMO_SWAP: begin
                res.new_word = entry.data_0;
                res.write_en = 1'b1;
            end
            CAS: begin
                if (old == entry.data_1) begin
                    res.new_word = entry.data_0;
                    res.write_en = 1'b1;
                end
            end
            default: ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cohort_req_fifo.sv
// Synchronous request FIFO of req_entry_t; ready is registered from the next
// occupancy so it never depends combinationally on pop.
module cohort_req_fifo
    import cohort_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  req_entry_t push_entry,
    input  logic       pop,
    output req_entry_t head,
    output logic       empty,
    output logic       ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    req_entry_t       entries_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             ready_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            ready_reg <= (count_next != FULL_COUNT);
        end
    end

    assign head  = entries_reg[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign ready = ready_reg;

endmodule

// File: rtl/cohort_mem_responder.sv
// Memory-side responder: executes queued load/store/atomic requests in order
// against a local word SRAM and returns one tagged response per request.
module cohort_mem_responder
    import cohort_resp_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int REQ_DEPTH    = 4,
    parameter int RESP_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_type,
    input  logic [TAG_W-1:0]  req_mshrid,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [MASK_W-1:0] req_write_mask,
    input  logic [DATA_W-1:0] req_data_0,
    input  logic [DATA_W-1:0] req_data_1,
    output logic              resp_valid,
    output logic [TAG_W-1:0]  resp_mshrid,
    output logic [DATA_W-1:0] resp_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD =
        LAT_W'((RESP_LATENCY > 0) ? RESP_LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e            state_reg;
    logic [LAT_W-1:0]  wait_cnt_reg;
    req_entry_t        cur_entry_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              resp_valid_reg;
    logic [TAG_W-1:0]  resp_mshrid_reg;
    logic [DATA_W-1:0] resp_data_reg;

    req_entry_t        push_entry;
    req_entry_t        fifo_head;
    logic              fifo_empty;
    logic              fifo_ready;
    logic              push;
    logic              pop;
    amo_result_t       amo_res;
    logic              mem_we;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign push_entry.req_type   = req_type_e'(req_type);
    assign push_entry.mshrid     = req_mshrid;
    assign push_entry.address    = req_address;
    assign push_entry.write_mask = req_write_mask;
    assign push_entry.data_0     = req_data_0;
    assign push_entry.data_1     = req_data_1;

    assign push = req_valid && fifo_ready;
    // A new request may start both from IDLE and in the response cycle.
    assign pop  = !fifo_empty && (state_reg == ST_IDLE || state_reg == ST_RESP);

    cohort_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .ready      (fifo_ready)
    );

    // Upper address bits are dropped so addresses alias modulo DEPTH words.
    assign rd_idx = fifo_head.address[3 +: IDX_W];
    assign wr_idx = cur_entry_reg.address[3 +: IDX_W];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur_entry_reg.address[ADDR_W-1:IDX_W+3],
                                cur_entry_reg.address[2:0]};

    always_comb begin
        amo_res = amo_compute(rdata_reg, cur_entry_reg);
    end

    assign mem_we = rst_n && (state_reg == ST_EXEC) && amo_res.write_en;

    // Reads and writes fall in different FSM states, so no collision handling.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= amo_res.new_word;
        end
        if (pop) begin
            rdata_reg <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            wait_cnt_reg    <= '0;
            cur_entry_reg   <= '0;
            resp_valid_reg  <= 1'b0;
            resp_mshrid_reg <= '0;
            resp_data_reg   <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            if (pop) begin
                cur_entry_reg <= fifo_head;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    resp_mshrid_reg <= cur_entry_reg.mshrid;
                    resp_data_reg   <= (cur_entry_reg.req_type == STORE) ? '0 : rdata_reg;
                    if (RESP_LATENCY == 0) begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                    end else begin
                        state_reg    <= ST_WAIT;
                        wait_cnt_reg <= LAT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg <= fifo_empty ? ST_IDLE : ST_EXEC;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = fifo_ready;
    assign resp_valid  = resp_valid_reg;
    assign resp_mshrid = resp_mshrid_reg;
    assign resp_data   = resp_data_reg;

endmodule

// File: tb/tb_cohort_mem_responder.sv
// Directed bench for cohort_mem_responder: hand-computed vectors, responses
// collected by a monitor and compared in order.
module tb_cohort_mem_responder;

    localparam logic [2:0] T_LOAD  = 3'd0;
    localparam logic [2:0] T_STORE = 3'd1;
    localparam logic [2:0] T_ADD   = 3'd2;
    localparam logic [2:0] T_SWAP  = 3'd3;
    localparam logic [2:0] T_CAS   = 3'd4;
    // Accept edge ends cycle t; the response is visible in cycle t+5 (RESP_LATENCY=2).
    localparam int RESP_EDGES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [7:0]  req_mshrid;
    logic [39:0] req_address;
    logic [7:0]  req_write_mask;
    logic [63:0] req_data_0;
    logic [63:0] req_data_1;
    logic        resp_valid;
    logic [7:0]  resp_mshrid;
    logic [63:0] resp_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [7:0]  q_m [$];
    logic [63:0] q_d [$];
    int          q_c [$];

    cohort_mem_responder #(
        .DEPTH        (1024),
        .REQ_DEPTH    (4),
        .RESP_LATENCY (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_mshrid     (req_mshrid),
        .req_address    (req_address),
        .req_write_mask (req_write_mask),
        .req_data_0     (req_data_0),
        .req_data_1     (req_data_1),
        .resp_valid     (resp_valid),
        .resp_mshrid    (resp_mshrid),
        .resp_data      (resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resp_valid) begin
            q_m.push_back(resp_mshrid);
            q_d.push_back(resp_data);
            q_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_m.delete();
        q_d.delete();
        q_c.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] t, input logic [7:0] id, input logic [39:0] a,
                        input logic [7:0] m, input logic [63:0] d0, input logic [63:0] d1);
        int n;
        req_valid      = 1'b1;
        req_type       = t;
        req_mshrid     = id;
        req_address    = a;
        req_write_mask = m;
        req_data_0     = d0;
        req_data_1     = d1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_at_accept", 64'(req_ready), 64'd1);
        @(negedge clk);
        accept_cyc = cyc;
        req_valid  = 1'b0;
    endtask

    task automatic wait_resps(input int n);
        int k;
        k = 0;
        while (q_m.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("resp_count", 64'(q_m.size()), 64'(n));
    endtask

    task automatic txn(input string tag, input logic [2:0] t, input logic [7:0] id,
                       input logic [39:0] a, input logic [7:0] m, input logic [63:0] d0,
                       input logic [63:0] d1, input logic [63:0] exp_data);
        logic [7:0]  got_m;
        logic [63:0] got_d;
        int          got_c;
        @(negedge clk);
        clear_q();
        send(t, id, a, m, d0, d1);
        wait_resps(1);
        if (q_m.size() > 0) begin
            got_m = q_m.pop_front();
            got_d = q_d.pop_front();
            got_c = q_c.pop_front();
            check({tag, "_mshrid"}, 64'(got_m), 64'(id));
            check({tag, "_data"}, got_d, exp_data);
            check({tag, "_latency"}, 64'(got_c - accept_cyc), 64'(RESP_EDGES));
            $display("txn %s type=%0d mshrid=%02h addr=%h -> resp mshrid=%02h data=%h",
                     tag, t, id, a, got_m, got_d);
        end
    endtask

    initial begin
        int accepted;
        int first_drop;
        int n;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_type = '0;
        req_mshrid = '0;
        req_address = '0;
        req_write_mask = '0;
        req_data_0 = '0;
        req_data_1 = '0;

        // 1. Reset state, then idle.
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_mshrid", 64'(resp_mshrid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        repeat (6) @(negedge clk);
        check("idle_no_resp", 64'(q_m.size()), 64'd0);

        // 2. Store then load back.
        txn("store40", T_STORE, 8'h80, 40'h40, 8'hFF, 64'hDEADBEEF_CAFEF00D, 64'd0, 64'd0);
        txn("load40", T_LOAD, 8'h81, 40'h40, 8'h00, 64'd0, 64'd0, 64'hDEADBEEF_CAFEF00D);

        // 3. Partial store.
        txn("fill80", T_STORE, 8'h20, 40'h80, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 64'd0);
        txn("part80", T_STORE, 8'h21, 40'h80, 8'h0F, 64'h11111111_22222222, 64'd0, 64'd0);
        txn("load80", T_LOAD, 8'h22, 40'h80, 8'h00, 64'd0, 64'd0, 64'hFFFFFFFF_22222222);

        // 4. Atomics on a word holding 5.
        txn("initC0", T_STORE, 8'h30, 40'hC0, 8'hFF, 64'd5, 64'd0, 64'd0);
        txn("amo_add", T_ADD, 8'h31, 40'hC0, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 64'd5);
        txn("cas_miss", T_CAS, 8'h32, 40'hC0, 8'h00, 64'd9, 64'd3, 64'd4);
        txn("after_miss", T_LOAD, 8'h33, 40'hC0, 8'h00, 64'd0, 64'd0, 64'd4);
        txn("cas_hit", T_CAS, 8'h34, 40'hC0, 8'h00, 64'd9, 64'd4, 64'd4);
        txn("after_hit", T_LOAD, 8'h35, 40'hC0, 8'h00, 64'd0, 64'd0, 64'd9);
        txn("amo_swap", T_SWAP, 8'h36, 40'hC0, 8'h00, 64'd7, 64'd0, 64'd9);
        txn("after_swap", T_LOAD, 8'h37, 40'hC0, 8'h00, 64'd0, 64'd0, 64'd7);

        // 5. Burst of 8 AMO_ADD 1 with req_valid held; responses count 0..7.
        txn("init300", T_STORE, 8'h0F, 40'h300, 8'hFF, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        clear_q();
        accepted = 0;
        first_drop = -1;
        n = 0;
        req_valid = 1'b1;
        while (accepted < 8 && n < 300) begin
            req_type       = T_ADD;
            req_mshrid     = 8'h10 + 8'(accepted);
            req_address    = 40'h300;
            req_write_mask = 8'h00;
            req_data_0     = 64'd1;
            req_data_1     = 64'd0;
            if (req_ready) begin
                @(negedge clk);
                accepted++;
            end else begin
                if (first_drop < 0) first_drop = accepted;
                @(negedge clk);
            end
            n++;
        end
        req_valid = 1'b0;
        check("burst_accepted", 64'(accepted), 64'd8);
        // One request leaves for execution at once, then four more fill the FIFO.
        check("burst_accepts_before_full", 64'(first_drop), 64'd5);
        wait_resps(8);
        for (int i = 0; i < 8; i++) begin
            if (q_m.size() > 0) begin
                check("burst_mshrid", 64'(q_m.pop_front()), 64'(8'h10 + 8'(i)));
                check("burst_data", q_d.pop_front(), 64'(i));
                $display("txn burst[%0d] checked", i);
            end
        end

        // 6. Reset while a load sits in WAIT and another is queued.
        @(negedge clk);
        clear_q();
        send(T_LOAD, 8'h55, 40'h40, 8'h00, 64'd0, 64'd0);
        send(T_LOAD, 8'h56, 40'h40, 8'h00, 64'd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_resp_mshrid", 64'(resp_mshrid), 64'd0);
        check("midrst_resp_data", resp_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", 64'(req_ready), 64'd1);
        repeat (12) @(negedge clk);
        check("dropped_no_resp", 64'(q_m.size()), 64'd0);
        txn("keep40", T_LOAD, 8'h60, 40'h40, 8'h00, 64'd0, 64'd0, 64'hDEADBEEF_CAFEF00D);
        txn("alias40", T_LOAD, 8'h61, 40'h2040, 8'h00, 64'd0, 64'd0, 64'hDEADBEEF_CAFEF00D);
        txn("keep80", T_LOAD, 8'h62, 40'h80, 8'h00, 64'd0, 64'd0, 64'hFFFFFFFF_22222222);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
